// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader
// Description : Loads a length-prefixed, XOR-checksummed byte image into main
//               memory as little-endian words and holds the core in reset
//               until the image has been verified.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_loader #(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h200,
    parameter int          MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] words_loaded
);

    localparam logic [2:0] c_LEN   = 3'd0;
    localparam logic [2:0] c_DATA  = 3'd1;
    localparam logic [2:0] c_CHECK = 3'd2;
    localparam logic [2:0] c_DONE  = 3'd3;
    localparam logic [2:0] c_ERROR = 3'd4;

    localparam logic [31:0] c_MAX_WORDS = 32'(MAX_WORDS);

    logic [2:0]            r_state;
    logic [1:0]            r_byte_cnt;
    logic [31:0]           r_len;
    logic [31:0]           r_word;
    logic [7:0]            r_csum;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic [ADDR_WIDTH-1:0] r_words_loaded;

    logic                  w_accept;
    logic [31:0]           w_len_next;
    logic [31:0]           w_word_next;
    logic                  w_last_word;

    assign in_ready = !reset && (r_state == c_LEN || r_state == c_DATA || r_state == c_CHECK);
    assign w_accept = in_valid && in_ready;

    // Bytes enter at the top and shift down, so the first byte ends in [7:0].
    assign w_len_next  = {in_data, r_len[31:8]};
    assign w_word_next = {in_data, r_word[31:8]};
    assign w_last_word = (32'(r_words_loaded) + 32'd1) == r_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_LEN;
            r_byte_cnt     <= 2'd0;
            r_len          <= 32'd0;
            r_word         <= 32'd0;
            r_csum         <= 8'd0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= 32'd0;
            r_words_loaded <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    c_LEN: begin
                        r_len      <= w_len_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            if (w_len_next == 32'd0)
                                r_state <= c_CHECK;
                            else if (w_len_next > c_MAX_WORDS)
                                r_state <= c_ERROR;
                            else
                                r_state <= c_DATA;
                        end
                    end
                    c_DATA: begin
                        r_word     <= w_word_next;
                        r_csum     <= r_csum ^ in_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            // Word index equals the count written so far.
                            r_mem_we       <= 1'b1;
                            r_mem_addr     <= ADDR_WIDTH'(BASE_ADDR) + (r_words_loaded << 2);
                            r_mem_wdata    <= w_word_next;
                            r_words_loaded <= r_words_loaded + 1'b1;
                            if (w_last_word)
                                r_state <= c_CHECK;
                        end
                    end
                    c_CHECK: begin
                        r_state <= (in_data == r_csum) ? c_DONE : c_ERROR;
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign words_loaded = r_words_loaded;
    assign done         = (r_state == c_DONE);
    assign error        = (r_state == c_ERROR);
    assign core_reset   = (r_state != c_DONE);

endmodule
`default_nettype wire
